// File: rtl/ram_arb_ctrl_pkg.sv
// ram_arb_pkg: shared types for the RAM sequencer/arbiter.
//   ram_arb_state_e : top-level FSM states
//   NREQ            : number of requesters sharing the RAM
//   rd_tag_t        : read-return pipeline tag {valid, requester id}
package ram_arb_pkg;
  typedef enum logic {ST_INIT, ST_ARB} ram_arb_state_e;
  localparam int NREQ = 2;
  typedef struct packed {
    logic vld;
    logic id;
  } rd_tag_t;
endpackage

// File: rtl/ram_arb_ctrl_if.sv
// ram_arb_ctrl_if: requester-side bus of ram_arb_ctrl.
//   req_valid/req_ready/req_we : per requester, [0]=m0 [1]=m1
//   req_addr/req_wdata         : packed per requester, m1 in the upper lane
//   rsp_valid                  : one-cycle read-data strobe per requester
//   rsp_rdata                  : shared read data
// master = requesters, slave = arbiter.
interface ram_arb_ctrl_if
  import ram_arb_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = 4
);
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0]         req_we;
  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0][DW-1:0] req_wdata;
  logic [NREQ-1:0]         rsp_valid;
  logic [DW-1:0]           rsp_rdata;

  modport master (output req_valid, req_we, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/ram_arb_ctrl_rr_arb2.sv
// rr_arb2: 2-way round-robin arbiter.
//   clk, rst_n : clock, async active-low reset
//   req        : request vector (already qualified by the caller)
//   advance    : a grant was consumed this cycle; move the pointer
//   grant      : one-hot grant, combinational from req
// Pointer 0 favours requester 0. After a consumed grant the pointer moves
// to the requester that did not win.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= 1'b0;
    else if (advance) ptr <= grant[0];
  end
endmodule

// File: rtl/ram_arb_ctrl.sv
// ram_arb_ctrl: sequencer/arbiter in front of a single-port sync RAM.
// Clears all words to INIT_VAL after reset (or init_req), then shares the RAM
// between two requesters with round-robin valid/ready arbitration.
//   clk, rst_n  : clock, async active-low reset
//   init_req    : re-run the memory clear (only honoured while arbitrating)
//   init_done   : clear finished, arbitration enabled
//   bus         : requester bus (slave side)
//   ram_we/addr/din : registered RAM controls
//   ram_dout    : RAM read data, RD_LAT clocks after address sample
module ram_arb_ctrl
  import ram_arb_pkg::*;
#(
  parameter int            AW       = 4,
  parameter int            DW       = 4,
  parameter int            RD_LAT   = 1,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_req,
  output logic          init_done,
  ram_arb_ctrl_if.slave bus,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);
  ram_arb_state_e          state;
  logic [AW:0]             init_cnt;  // MSB set once the last word is written
  logic [NREQ-1:0]         arb_req;
  logic [NREQ-1:0]         grant;
  logic                    hs;
  logic                    hs_id;
  rd_tag_t [RD_LAT:0]      tag_pipe;

  assign arb_req       = (state == ST_ARB) ? bus.req_valid : '0;
  assign bus.req_ready = grant;
  assign hs            = |grant;      // grant only asserts on a valid request
  assign hs_id         = grant[1];

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (hs),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (!init_cnt[AW]) begin
            ram_we   <= 1'b1;
            ram_addr <= init_cnt[AW-1:0];
            ram_din  <= INIT_VAL;
            init_cnt <= init_cnt + {{AW{1'b0}}, 1'b1};
          end else begin
            ram_we    <= 1'b0;
            state     <= ST_ARB;
            init_done <= 1'b1;
          end
        end
        ST_ARB: begin
          ram_we <= 1'b0;
          if (hs) begin
            ram_we   <= bus.req_we[hs_id];
            ram_addr <= bus.req_addr[hs_id];
            ram_din  <= bus.req_wdata[hs_id];
          end
          // The handshake in this cycle is still issued; the clear follows it.
          if (init_req) begin
            state     <= ST_INIT;
            init_done <= 1'b0;
            init_cnt  <= '0;
          end
        end
      endcase
    end
  end

  // Read-return tags: stage 0 loads with the issue register, so stage RD_LAT
  // lines up with ram_dout carrying that read's data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pipe      <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_rdata <= '0;
    end else begin
      tag_pipe[0] <= '{vld: hs & ~bus.req_we[hs_id], id: hs_id};
      for (int i = 1; i <= RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      bus.rsp_valid <= '0;
      if (tag_pipe[RD_LAT].vld) begin
        bus.rsp_valid[tag_pipe[RD_LAT].id] <= 1'b1;
        bus.rsp_rdata                      <= ram_dout;
      end
    end
  end
endmodule
